toy_bus_dslice_req_ack: RTL and testbench

//  Per-target register slice on one decoder output port: 2-entry skid buffer on the ToyBusReq forward

---
 rtl/toy_bus_dslice_req_ack.sv | 203 ++++++++++++++++++++
 tb/tb_toy_bus_dslice_req_ack.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toy_bus_dslice_req_ack.sv
// Per-target register slice for one decoder output port of the toy bus.
// Request path: 2-entry skid FIFO toward the target node. Ack path: 2-entry
// skid FIFO back toward the ack arbiter. Requests leaving toward the target
// are capped by an in-flight counter (MAX_OUTSTANDING).
// Optional watchdog: define TOY_BUS_SLICE_TIMEOUT_EN to enable a sticky
// timeout_err flag after TIMEOUT_CYCLES cycles without ack progress.
//
// Handshake: a beat transfers on a rising clk edge where vld & rdy are both 1.
// A producer that raised vld keeps vld and payload stable until accepted.
// Every rdy driven by this block comes straight from a registered FIFO
// count, so there is no combinational path from a downstream rdy to an
// upstream rdy.

// 2-entry FIFO used as a skid buffer on either channel.
module toy_bus_dslice_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  output logic         o_rdy,
  input  logic         i_pop,
  output logic         o_nonempty,
  output logic [W-1:0] o_head
);
  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  assign o_rdy      = (r_count != 2'd2);
  assign o_nonempty = (r_count != 2'd0);
  assign o_head     = r_mem[r_rd_ptr];
  // A push while full is refused (rdy was 0); a pop while full still happens.
  assign w_push     = i_push & o_rdy;
  assign w_pop      = i_pop & o_nonempty;

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module toy_bus_dslice_req_ack #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic         clk,
  input  logic         rst,
  // request from decoder output
  input  logic         i_in_req_vld,
  output logic         o_in_req_rdy,
  input  logic [31:0]  i_in_req_addr,
  input  logic [31:0]  i_in_req_strb,
  input  logic [255:0] i_in_req_data,
  input  logic         i_in_req_opcode,
  input  logic [3:0]   i_in_req_src_id,
  input  logic [3:0]   i_in_req_tgt_id,
  input  logic [9:0]   i_in_req_sideband,
  // request to target node
  output logic         o_out_req_vld,
  input  logic         i_out_req_rdy,
  output logic [31:0]  o_out_req_addr,
  output logic [31:0]  o_out_req_strb,
  output logic [255:0] o_out_req_data,
  output logic         o_out_req_opcode,
  output logic [3:0]   o_out_req_src_id,
  output logic [3:0]   o_out_req_tgt_id,
  output logic [9:0]   o_out_req_sideband,
  // ack from target node
  input  logic         i_out_ack_vld,
  output logic         o_out_ack_rdy,
  input  logic         i_out_ack_opcode,
  input  logic [255:0] i_out_ack_data,
  input  logic [9:0]   i_out_ack_sideband,
  input  logic [3:0]   i_out_ack_src_id,
  input  logic [3:0]   i_out_ack_tgt_id,
  // ack toward ack arbiter
  output logic         o_in_ack_vld,
  input  logic         i_in_ack_rdy,
  output logic         o_in_ack_opcode,
  output logic [255:0] o_in_ack_data,
  output logic [9:0]   o_in_ack_sideband,
  output logic [3:0]   o_in_ack_src_id,
  output logic [3:0]   o_in_ack_tgt_id,
  // status
  output logic [3:0]   o_outstanding,
  output logic         o_timeout_err
);
  localparam int REQ_W = 32 + 32 + 256 + 1 + 4 + 4 + 10;
  localparam int ACK_W = 1 + 256 + 10 + 4 + 4;

  // Out-of-range parameters are rejected at elaboration.
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
    $error("toy_bus_dslice_req_ack: parameter out of range");
  end

  logic [REQ_W-1:0] w_req_in;
  logic [REQ_W-1:0] w_req_head;
  logic             w_req_nonempty;
  logic [ACK_W-1:0] w_ack_in;
  logic [ACK_W-1:0] w_ack_head;
  logic             w_req_hs;
  logic             w_ack_hs;
  logic [3:0]       r_outstanding;

  assign w_req_in = {i_in_req_addr, i_in_req_strb, i_in_req_data, i_in_req_opcode,
                     i_in_req_src_id, i_in_req_tgt_id, i_in_req_sideband};
  assign w_ack_in = {i_out_ack_opcode, i_out_ack_data, i_out_ack_sideband,
                     i_out_ack_src_id, i_out_ack_tgt_id};

  // Requests toward the target are held back once the in-flight cap is hit.
  assign o_out_req_vld = w_req_nonempty & (r_outstanding < 4'(MAX_OUTSTANDING));
  assign w_req_hs      = o_out_req_vld & i_out_req_rdy;
  assign w_ack_hs      = i_out_ack_vld & o_out_ack_rdy;

  toy_bus_dslice_skid #(.W(REQ_W)) u_req_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (i_in_req_vld),
    .i_data     (w_req_in),
    .o_rdy      (o_in_req_rdy),
    .i_pop      (w_req_hs),
    .o_nonempty (w_req_nonempty),
    .o_head     (w_req_head)
  );

  toy_bus_dslice_skid #(.W(ACK_W)) u_ack_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (i_out_ack_vld),
    .i_data     (w_ack_in),
    .o_rdy      (o_out_ack_rdy),
    .i_pop      (o_in_ack_vld & i_in_ack_rdy),
    .o_nonempty (o_in_ack_vld),
    .o_head     (w_ack_head)
  );

  assign {o_out_req_addr, o_out_req_strb, o_out_req_data, o_out_req_opcode,
          o_out_req_src_id, o_out_req_tgt_id, o_out_req_sideband} = w_req_head;
  assign {o_in_ack_opcode, o_in_ack_data, o_in_ack_sideband,
          o_in_ack_src_id, o_in_ack_tgt_id} = w_ack_head;

  // In-flight counter: +1 per request sent, -1 per ack received, floor at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outstanding <= 4'd0;
    end else if (w_req_hs && !w_ack_hs) begin
      r_outstanding <= r_outstanding + 4'd1;
    end else if (w_ack_hs && !w_req_hs && r_outstanding != 4'd0) begin
      r_outstanding <= r_outstanding - 4'd1;
    end
  end

  assign o_outstanding = r_outstanding;

`ifdef TOY_BUS_SLICE_TIMEOUT_EN
  logic [15:0] r_wd_cnt;
  logic        r_timeout_err;

  // Watchdog: counts cycles with requests in flight and no ack returning.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd_cnt      <= 16'd0;
      r_timeout_err <= 1'b0;
    end else if (w_ack_hs || r_outstanding == 4'd0) begin
      r_wd_cnt <= 16'd0;
    end else if (r_wd_cnt != 16'(TIMEOUT_CYCLES)) begin
      r_wd_cnt <= r_wd_cnt + 16'd1;
      if (r_wd_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign o_timeout_err = r_timeout_err;
`else
  assign o_timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_toy_bus_dslice_req_ack.sv
// Bench for toy_bus_dslice_req_ack: reset state, single-request latency,
// table of request/ack vectors, in-flight cap, ack backpressure, same-cycle
// req/ack, stray ack, watchdog (when TOY_BUS_SLICE_TIMEOUT_EN) and reset
// mid-stream. Payload order is checked by per-channel expected queues.
module tb_toy_bus_dslice_req_ack;
  localparam int MAX_OUT = 4;
  localparam int TB_TIMEOUT = 16;
`ifdef TOY_BUS_SLICE_TIMEOUT_EN
  localparam logic EXP_WD = 1'b1;
`else
  localparam logic EXP_WD = 1'b0;
`endif

  typedef logic [338:0] req_t;
  typedef logic [274:0] ack_t;

  typedef struct {
    req_t req;
    ack_t ack;
    int   exp_out_after_req;
    int   exp_out_after_ack;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic         i_in_req_vld = 1'b0;
  logic         o_in_req_rdy;
  logic [31:0]  i_in_req_addr = '0;
  logic [31:0]  i_in_req_strb = '0;
  logic [255:0] i_in_req_data = '0;
  logic         i_in_req_opcode = 1'b0;
  logic [3:0]   i_in_req_src_id = '0;
  logic [3:0]   i_in_req_tgt_id = '0;
  logic [9:0]   i_in_req_sideband = '0;
  logic         o_out_req_vld;
  logic         i_out_req_rdy = 1'b0;
  logic [31:0]  o_out_req_addr;
  logic [31:0]  o_out_req_strb;
  logic [255:0] o_out_req_data;
  logic         o_out_req_opcode;
  logic [3:0]   o_out_req_src_id;
  logic [3:0]   o_out_req_tgt_id;
  logic [9:0]   o_out_req_sideband;
  logic         i_out_ack_vld = 1'b0;
  logic         o_out_ack_rdy;
  logic         i_out_ack_opcode = 1'b0;
  logic [255:0] i_out_ack_data = '0;
  logic [9:0]   i_out_ack_sideband = '0;
  logic [3:0]   i_out_ack_src_id = '0;
  logic [3:0]   i_out_ack_tgt_id = '0;
  logic         o_in_ack_vld;
  logic         i_in_ack_rdy = 1'b1;
  logic         o_in_ack_opcode;
  logic [255:0] o_in_ack_data;
  logic [9:0]   o_in_ack_sideband;
  logic [3:0]   o_in_ack_src_id;
  logic [3:0]   o_in_ack_tgt_id;
  logic [3:0]   o_outstanding;
  logic         o_timeout_err;

  // clock / reset block
  always #5 clk = ~clk;

  toy_bus_dslice_req_ack #(.MAX_OUTSTANDING(MAX_OUT), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_in_req_vld(i_in_req_vld), .o_in_req_rdy(o_in_req_rdy),
    .i_in_req_addr(i_in_req_addr), .i_in_req_strb(i_in_req_strb),
    .i_in_req_data(i_in_req_data), .i_in_req_opcode(i_in_req_opcode),
    .i_in_req_src_id(i_in_req_src_id), .i_in_req_tgt_id(i_in_req_tgt_id),
    .i_in_req_sideband(i_in_req_sideband),
    .o_out_req_vld(o_out_req_vld), .i_out_req_rdy(i_out_req_rdy),
    .o_out_req_addr(o_out_req_addr), .o_out_req_strb(o_out_req_strb),
    .o_out_req_data(o_out_req_data), .o_out_req_opcode(o_out_req_opcode),
    .o_out_req_src_id(o_out_req_src_id), .o_out_req_tgt_id(o_out_req_tgt_id),
    .o_out_req_sideband(o_out_req_sideband),
    .i_out_ack_vld(i_out_ack_vld), .o_out_ack_rdy(o_out_ack_rdy),
    .i_out_ack_opcode(i_out_ack_opcode), .i_out_ack_data(i_out_ack_data),
    .i_out_ack_sideband(i_out_ack_sideband), .i_out_ack_src_id(i_out_ack_src_id),
    .i_out_ack_tgt_id(i_out_ack_tgt_id),
    .o_in_ack_vld(o_in_ack_vld), .i_in_ack_rdy(i_in_ack_rdy),
    .o_in_ack_opcode(o_in_ack_opcode), .o_in_ack_data(o_in_ack_data),
    .o_in_ack_sideband(o_in_ack_sideband), .o_in_ack_src_id(o_in_ack_src_id),
    .o_in_ack_tgt_id(o_in_ack_tgt_id),
    .o_outstanding(o_outstanding), .o_timeout_err(o_timeout_err)
  );

  req_t w_in_req, w_out_req;
  ack_t w_out_ack, w_in_ack;
  assign w_in_req  = {i_in_req_addr, i_in_req_strb, i_in_req_data, i_in_req_opcode,
                      i_in_req_src_id, i_in_req_tgt_id, i_in_req_sideband};
  assign w_out_req = {o_out_req_addr, o_out_req_strb, o_out_req_data, o_out_req_opcode,
                      o_out_req_src_id, o_out_req_tgt_id, o_out_req_sideband};
  assign w_out_ack = {i_out_ack_opcode, i_out_ack_data, i_out_ack_sideband,
                      i_out_ack_src_id, i_out_ack_tgt_id};
  assign w_in_ack  = {o_in_ack_opcode, o_in_ack_data, o_in_ack_sideband,
                      o_in_ack_src_id, o_in_ack_tgt_id};

  int n_checks = 0;
  int n_pass = 0;
  int n_out_hs = 0;
  int m_out = 0;
  logic drv_done = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: event did not match expectation", name);
  endtask

  // scoreboard: expected queues filled at the input handshake, drained at the output
  logic [338:0] req_exp_q[$];
  logic [274:0] ack_exp_q[$];

  // Monitor on the falling edge: values seen here are what the next rising edge uses.
  always @(negedge clk) begin
    logic req_hs, ack_hs;
    if (rst) begin
      req_exp_q.delete();
      ack_exp_q.delete();
      m_out = 0;
    end else begin
      check("outstanding_track", 512'(o_outstanding), 512'(m_out));
      if (o_out_req_vld && m_out >= MAX_OUT) fail_now("req_over_cap");
      req_hs = o_out_req_vld & i_out_req_rdy;
      ack_hs = i_out_ack_vld & o_out_ack_rdy;
      if (i_in_req_vld && o_in_req_rdy) req_exp_q.push_back(w_in_req);
      if (req_hs) begin
        n_out_hs++;
        if (req_exp_q.size() == 0) fail_now("req_unexpected");
        else check("req_payload", 512'(w_out_req), 512'(req_exp_q.pop_front()));
      end
      if (ack_hs) ack_exp_q.push_back(w_out_ack);
      if (o_in_ack_vld && i_in_ack_rdy) begin
        if (ack_exp_q.size() == 0) fail_now("ack_unexpected");
        else check("ack_payload", 512'(w_in_ack), 512'(ack_exp_q.pop_front()));
      end
      if (req_hs && !ack_hs) m_out++;
      else if (ack_hs && !req_hs && m_out > 0) m_out--;
    end
  end

  function automatic req_t mk_req(input logic [31:0] addr, input logic [3:0] src);
    logic [255:0] d;
    for (int j = 0; j < 8; j++) d[j*32 +: 32] = 32'($urandom_range(0, 32'hFFFF_FFFF));
    return {addr, 32'($urandom_range(0, 32'hFFFF_FFFF)), d, 1'($urandom_range(0, 1)),
            src, 4'($urandom_range(0, 15)), 10'($urandom_range(0, 1023))};
  endfunction

  function automatic ack_t mk_ack(input logic [255:0] d);
    return {1'($urandom_range(0, 1)), d, 10'($urandom_range(0, 1023)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
  endfunction

  // driver tasks: called just after a rising edge, return just after one
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input req_t p);
    logic hs;
    int n;
    n = 0;
    i_in_req_vld = 1'b1;
    {i_in_req_addr, i_in_req_strb, i_in_req_data, i_in_req_opcode,
     i_in_req_src_id, i_in_req_tgt_id, i_in_req_sideband} = p;
    do begin
      @(negedge clk); hs = o_in_req_rdy;
      @(posedge clk); #1; n++;
    end while (!hs && n < 500);
    if (!hs) fail_now("req_accept_timeout");
    i_in_req_vld = 1'b0;
  endtask

  task automatic drive_ack(input ack_t p);
    logic hs;
    int n;
    n = 0;
    i_out_ack_vld = 1'b1;
    {i_out_ack_opcode, i_out_ack_data, i_out_ack_sideband,
     i_out_ack_src_id, i_out_ack_tgt_id} = p;
    do begin
      @(negedge clk); hs = o_out_ack_rdy;
      @(posedge clk); #1; n++;
    end while (!hs && n < 500);
    if (!hs) fail_now("ack_accept_timeout");
    i_out_ack_vld = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    vec_t vecs[4];
    req_t r;
    ack_t a1, a2;
    logic [255:0] a5;
    int base_hs;
    int n;
    a5 = {32{8'hA5}};
    for (int i = 0; i < 4; i++) begin
      vecs[i].req = mk_req(32'h2000 + 32'(i * 64), 4'(i + 5));
      vecs[i].ack = mk_ack({8{32'(i * 32'h1111_1111)}});
      vecs[i].exp_out_after_req = i + 1;
      vecs[i].exp_out_after_ack = 3 - i;
    end

    // reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_req_rdy", 512'(o_in_req_rdy), 512'(1));
    check("rst_out_ack_rdy", 512'(o_out_ack_rdy), 512'(1));
    check("rst_out_req_vld", 512'(o_out_req_vld), 512'(0));
    check("rst_in_ack_vld", 512'(o_in_ack_vld), 512'(0));
    check("rst_outstanding", 512'(o_outstanding), 512'(0));
    check("rst_timeout_err", 512'(o_timeout_err), 512'(0));
    check("rst_out_req_payload", 512'(w_out_req), 512'(0));
    check("rst_in_ack_payload", 512'(w_in_ack), 512'(0));
    @(posedge clk); #1;

    // single request: addr 0x100, src 2, one cycle latency
    i_out_req_rdy = 1'b1;
    r = mk_req(32'h100, 4'd2);
    {i_in_req_addr, i_in_req_strb, i_in_req_data, i_in_req_opcode,
     i_in_req_src_id, i_in_req_tgt_id, i_in_req_sideband} = r;
    i_in_req_vld = 1'b1;
    @(negedge clk);
    check("t1_out_vld_before", 512'(o_out_req_vld), 512'(0));
    @(posedge clk); #1 i_in_req_vld = 1'b0;
    @(negedge clk);
    check("t1_out_vld_after", 512'(o_out_req_vld), 512'(1));
    check("t1_addr", 512'(o_out_req_addr), 512'(32'h100));
    check("t1_src_id", 512'(o_out_req_src_id), 512'(2));
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_outstanding", 512'(o_outstanding), 512'(1));
    check("t1_out_vld_drained", 512'(o_out_req_vld), 512'(0));
    @(posedge clk); #1;
    drive_ack(mk_ack(256'h1));
    idle(2);

    // table vectors: reqs raise the count, acks lower it
    for (int i = 0; i < 4; i++) begin
      drive_req(vecs[i].req);
      idle(3);
      check($sformatf("vec%0d_out_after_req", i), 512'(o_outstanding),
            512'(vecs[i].exp_out_after_req));
    end
    for (int i = 0; i < 4; i++) begin
      drive_ack(vecs[i].ack);
      idle(2);
      check($sformatf("vec%0d_out_after_ack", i), 512'(o_outstanding),
            512'(vecs[i].exp_out_after_ack));
    end

    // 8 back-to-back reqs, no acks: cap at 4, buffer fills
    i_in_ack_rdy = 1'b0;
    base_hs = n_out_hs;
    fork
      begin
        for (int i = 0; i < 8; i++) drive_req(mk_req(32'h3000 + 32'(i), 4'(i)));
        drv_done = 1'b1;
      end
    join_none
    idle(12);
    @(negedge clk);
    check("t2_out_hs_count", 512'(n_out_hs - base_hs), 512'(4));
    check("t2_in_req_rdy", 512'(o_in_req_rdy), 512'(0));
    check("t2_outstanding", 512'(o_outstanding), 512'(4));
    check("t2_out_req_vld_gated", 512'(o_out_req_vld), 512'(0));
    check("t2_buffered", 512'(req_exp_q.size()), 512'(2));
    @(posedge clk); #1;

    // ack held for 3 cycles by the arbiter
    a1 = mk_ack(a5);
    drive_ack(a1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("t3_outstanding", 512'(o_outstanding), 512'(3));
        check("t3_next_req_vld", 512'(o_out_req_vld), 512'(1));
      end
      check("t3_in_ack_vld", 512'(o_in_ack_vld), 512'(1));
      check("t3_in_ack_stable", 512'(w_in_ack), 512'(a1));
      check("t3_out_ack_rdy", 512'(o_out_ack_rdy), 512'(1));
    end
    @(posedge clk); #1;
    a2 = mk_ack(~a5);
    drive_ack(a2);
    @(negedge clk);
    check("t3_out_ack_rdy_full", 512'(o_out_ack_rdy), 512'(0));
    check("t3_head_still_first", 512'(w_in_ack), 512'(a1));
    @(posedge clk); #1;
    i_in_ack_rdy = 1'b1;
    for (int i = 0; i < 6; i++) drive_ack(mk_ack(256'(i + 100)));
    n = 0;
    while (!drv_done && n < 200) begin idle(1); n++; end
    if (!drv_done) fail_now("t3_req_driver_stuck");
    idle(4);
    @(negedge clk);
    check("t3_drained_outstanding", 512'(o_outstanding), 512'(0));
    check("t3_req_q_empty", 512'(req_exp_q.size()), 512'(0));
    check("t3_ack_q_empty", 512'(ack_exp_q.size()), 512'(0));
    @(posedge clk); #1;

    // same-cycle req and ack at outstanding 2
    drive_req(mk_req(32'h4000, 4'd1));
    drive_req(mk_req(32'h4004, 4'd1));
    idle(3);
    i_out_req_rdy = 1'b0;
    drive_req(mk_req(32'h4008, 4'd1));
    idle(1);
    @(negedge clk);
    check("t4_outstanding_pre", 512'(o_outstanding), 512'(2));
    @(posedge clk); #1;
    i_out_req_rdy = 1'b1;
    i_out_ack_vld = 1'b1;
    {i_out_ack_opcode, i_out_ack_data, i_out_ack_sideband,
     i_out_ack_src_id, i_out_ack_tgt_id} = mk_ack(256'hBEEF);
    @(negedge clk);
    check("t4_req_vld", 512'(o_out_req_vld), 512'(1));
    check("t4_ack_rdy", 512'(o_out_ack_rdy), 512'(1));
    @(posedge clk); #1 i_out_ack_vld = 1'b0;
    @(negedge clk);
    check("t4_outstanding_same", 512'(o_outstanding), 512'(2));
    @(posedge clk); #1;
    drive_ack(mk_ack(256'hC0));
    drive_ack(mk_ack(256'hC1));
    idle(2);

    // stray ack with nothing in flight
    drive_ack(mk_ack(256'h5757));
    idle(3);
    @(negedge clk);
    check("t5_outstanding_zero", 512'(o_outstanding), 512'(0));
    check("t5_ack_forwarded", 512'(ack_exp_q.size()), 512'(0));
    @(posedge clk); #1;

    // watchdog: one req, no ack
    drive_req(mk_req(32'h5000, 4'd3));
    repeat (17) @(negedge clk);
    check("t6_wd_before_limit", 512'(o_timeout_err), 512'(0));
    @(negedge clk);
    check("t6_wd_at_limit", 512'(o_timeout_err), 512'(EXP_WD));
    repeat (5) @(negedge clk);
    check("t6_wd_sticky", 512'(o_timeout_err), 512'(EXP_WD));
    @(posedge clk); #1;

    // reset mid-stream with buffered reqs and acks
    i_out_req_rdy = 1'b0;
    i_in_ack_rdy = 1'b0;
    drive_req(mk_req(32'h6000, 4'd4));
    drive_req(mk_req(32'h6004, 4'd4));
    drive_ack(mk_ack(256'h77));
    rst = 1'b1;
    #2;
    check("t7_out_req_vld", 512'(o_out_req_vld), 512'(0));
    check("t7_in_ack_vld", 512'(o_in_ack_vld), 512'(0));
    check("t7_outstanding", 512'(o_outstanding), 512'(0));
    check("t7_timeout_err", 512'(o_timeout_err), 512'(0));
    check("t7_in_req_rdy", 512'(o_in_req_rdy), 512'(1));
    idle(2);
    rst = 1'b0;
    i_out_req_rdy = 1'b1;
    i_in_ack_rdy = 1'b1;
    @(negedge clk);
    check("t7_req_payload_zero", 512'(w_out_req), 512'(0));
    @(posedge clk); #1;
    drive_req(mk_req(32'h7000, 4'd6));
    drive_ack(mk_ack(256'h99));
    idle(3);
    @(negedge clk);
    check("t7_post_reset_outstanding", 512'(o_outstanding), 512'(0));
    check("t7_post_reset_q", 512'(req_exp_q.size() + ack_exp_q.size()), 512'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
